// File: rtl/svm_ctrl_driver_if.sv
// Command handshake and AXI-Lite control-port signals between the SVM invocation
// driver (master) and the HLS core's s_axi_control slave.
interface svm_ctrl_driver_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;

  logic [ADDR_W-1:0] m_axi_control_awaddr;
  logic              m_axi_control_awvalid;
  logic              m_axi_control_awready;

  logic [31:0]       m_axi_control_wdata;
  logic [3:0]        m_axi_control_wstrb;
  logic              m_axi_control_wvalid;
  logic              m_axi_control_wready;

  logic [1:0]        m_axi_control_bresp;
  logic              m_axi_control_bvalid;
  logic              m_axi_control_bready;

  logic [ADDR_W-1:0] m_axi_control_araddr;
  logic              m_axi_control_arvalid;
  logic              m_axi_control_arready;

  logic [31:0]       m_axi_control_rdata;
  logic [1:0]        m_axi_control_rresp;
  logic              m_axi_control_rvalid;
  logic              m_axi_control_rready;

  modport master (
    input  cmd_valid,
    output cmd_ready,
    output m_axi_control_awaddr, m_axi_control_awvalid,
    input  m_axi_control_awready,
    output m_axi_control_wdata, m_axi_control_wstrb, m_axi_control_wvalid,
    input  m_axi_control_wready,
    input  m_axi_control_bresp, m_axi_control_bvalid,
    output m_axi_control_bready,
    output m_axi_control_araddr, m_axi_control_arvalid,
    input  m_axi_control_arready,
    input  m_axi_control_rdata, m_axi_control_rresp, m_axi_control_rvalid,
    output m_axi_control_rready
  );

  modport slave (
    output cmd_valid,
    input  cmd_ready,
    input  m_axi_control_awaddr, m_axi_control_awvalid,
    output m_axi_control_awready,
    input  m_axi_control_wdata, m_axi_control_wstrb, m_axi_control_wvalid,
    output m_axi_control_wready,
    output m_axi_control_bresp, m_axi_control_bvalid,
    input  m_axi_control_bready,
    input  m_axi_control_araddr, m_axi_control_arvalid,
    output m_axi_control_arready,
    output m_axi_control_rdata, m_axi_control_rresp, m_axi_control_rvalid,
    input  m_axi_control_rready
  );
endinterface

// File: rtl/svm_ctrl_driver.sv
// Runs one SVM HLS core invocation over AXI-Lite: write ap_start, poll the control
// register for ap_done (clear-on-read), then report done/err and the poll count.
module svm_ctrl_driver #(
  parameter int unsigned       ADDR_W        = 8,
  parameter logic [ADDR_W-1:0] CTRL_ADDR     = '0,
  parameter int unsigned       POLL_GAP      = 16,
  parameter int unsigned       TIMEOUT_POLLS = 65535
) (
  input  logic               ap_clk,
  input  logic               ap_rst_n,
  svm_ctrl_driver_if.master  bus,
  output logic               busy,
  output logic               done,
  output logic [1:0]         err,
  output logic [15:0]        poll_cnt
);

  localparam int unsigned GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(POLL_GAP - 1);
  localparam logic [15:0] POLL_LIMIT = 16'(TIMEOUT_POLLS);

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_BRESP   = 2'd1;
  localparam logic [1:0] ERR_RRESP   = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_WR_RESP,
    S_RD_ADDR,
    S_RD_DATA,
    S_GAP,
    S_FIN
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_aw_done;
  logic             r_w_done;
  logic [GAP_W-1:0] r_gap_cnt;
  logic [1:0]       r_err;
  logic [15:0]      r_poll_cnt;

  logic             w_accept;
  logic             w_aw_hs;
  logic             w_w_hs;
  logic             w_ar_hs;
  logic             w_err_load;
  logic [1:0]       w_err_val;

  // All outputs decode from registered state only, so no ready->valid comb path.
  assign bus.cmd_ready             = (r_state == S_IDLE);
  assign bus.m_axi_control_awvalid = (r_state == S_WR) && !r_aw_done;
  assign bus.m_axi_control_awaddr  = bus.m_axi_control_awvalid ? CTRL_ADDR : '0;
  assign bus.m_axi_control_wvalid  = (r_state == S_WR) && !r_w_done;
  assign bus.m_axi_control_wdata   = bus.m_axi_control_wvalid ? 32'h1 : '0;
  assign bus.m_axi_control_wstrb   = bus.m_axi_control_wvalid ? 4'hF : '0;
  assign bus.m_axi_control_bready  = (r_state == S_WR_RESP);
  assign bus.m_axi_control_arvalid = (r_state == S_RD_ADDR);
  assign bus.m_axi_control_araddr  = bus.m_axi_control_arvalid ? CTRL_ADDR : '0;
  assign bus.m_axi_control_rready  = (r_state == S_RD_DATA);

  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_FIN);
  assign err      = r_err;
  assign poll_cnt = r_poll_cnt;

  assign w_accept = bus.cmd_valid && bus.cmd_ready;
  assign w_aw_hs  = bus.m_axi_control_awvalid && bus.m_axi_control_awready;
  assign w_w_hs   = bus.m_axi_control_wvalid && bus.m_axi_control_wready;
  assign w_ar_hs  = bus.m_axi_control_arvalid && bus.m_axi_control_arready;

  always_comb begin
    w_state_nxt = r_state;
    w_err_load  = 1'b0;
    w_err_val   = ERR_OK;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = S_WR;
      end
      S_WR: begin
        if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) w_state_nxt = S_WR_RESP;
      end
      S_WR_RESP: begin
        if (bus.m_axi_control_bvalid) begin
          if (bus.m_axi_control_bresp != 2'b00) begin
            w_err_load  = 1'b1;
            w_err_val   = ERR_BRESP;
            w_state_nxt = S_FIN;
          end else begin
            w_state_nxt = S_RD_ADDR;
          end
        end
      end
      S_RD_ADDR: begin
        if (w_ar_hs) w_state_nxt = S_RD_DATA;
      end
      S_RD_DATA: begin
        // r_poll_cnt already includes the poll whose data is arriving now.
        if (bus.m_axi_control_rvalid) begin
          w_state_nxt = S_FIN;
          w_err_load  = 1'b1;
          if (bus.m_axi_control_rresp != 2'b00) begin
            w_err_val = ERR_RRESP;
          end else if (bus.m_axi_control_rdata[1]) begin
            w_err_val = ERR_OK;
          end else if (r_poll_cnt == POLL_LIMIT) begin
            w_err_val = ERR_TIMEOUT;
          end else begin
            w_err_load  = 1'b0;
            w_state_nxt = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (r_gap_cnt == GAP_LAST) w_state_nxt = S_RD_ADDR;
      end
      S_FIN: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      r_state    <= S_IDLE;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
      r_gap_cnt  <= '0;
      r_err      <= ERR_OK;
      r_poll_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            r_err      <= ERR_OK;
            r_poll_cnt <= '0;
          end
        end
        S_WR: begin
          if (w_aw_hs) r_aw_done <= 1'b1;
          if (w_w_hs)  r_w_done  <= 1'b1;
        end
        S_RD_ADDR: begin
          if (w_ar_hs && (r_poll_cnt != '1)) r_poll_cnt <= r_poll_cnt + 16'd1;
        end
        S_RD_DATA: begin
          r_gap_cnt <= '0;
        end
        S_GAP: begin
          r_gap_cnt <= r_gap_cnt + GAP_W'(1);
        end
        default: begin
        end
      endcase
      if (w_err_load) r_err <= w_err_val;
    end
  end

  a_aw_hold: assert property (@(posedge ap_clk) disable iff (!ap_rst_n)
    bus.m_axi_control_awvalid && !bus.m_axi_control_awready
    |=> bus.m_axi_control_awvalid && $stable(bus.m_axi_control_awaddr));

  a_w_hold: assert property (@(posedge ap_clk) disable iff (!ap_rst_n)
    bus.m_axi_control_wvalid && !bus.m_axi_control_wready
    |=> bus.m_axi_control_wvalid && $stable(bus.m_axi_control_wdata));

  a_ar_hold: assert property (@(posedge ap_clk) disable iff (!ap_rst_n)
    bus.m_axi_control_arvalid && !bus.m_axi_control_arready
    |=> bus.m_axi_control_arvalid && $stable(bus.m_axi_control_araddr));

  a_done_pulse: assert property (@(posedge ap_clk) disable iff (!ap_rst_n)
    done |=> !done);

endmodule

// File: tb/tb_svm_ctrl_driver.sv
// Randomized bench for svm_ctrl_driver: scripted AXI-Lite slave plus a
// transaction-level model predicting err, poll count and completion latency.
module tb_svm_ctrl_driver;

  localparam int unsigned       ADDR_W        = 8;
  localparam logic [ADDR_W-1:0] CTRL_ADDR     = 8'h10;
  localparam int unsigned       POLL_GAP      = 16;
  localparam int unsigned       TIMEOUT_POLLS = 5;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic        busy;
  logic        done;
  logic [1:0]  err;
  logic [15:0] poll_cnt;

  svm_ctrl_driver_if #(.ADDR_W(ADDR_W)) bus ();

  svm_ctrl_driver #(
    .ADDR_W       (ADDR_W),
    .CTRL_ADDR    (CTRL_ADDR),
    .POLL_GAP     (POLL_GAP),
    .TIMEOUT_POLLS(TIMEOUT_POLLS)
  ) dut (
    .ap_clk  (ap_clk),
    .ap_rst_n(ap_rst_n),
    .bus     (bus.master),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .poll_cnt(poll_cnt)
  );

  always #5 ap_clk = ~ap_clk;

  int unsigned errors = 0;
  int unsigned checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Slave script for the current transaction (phase delays in cycles).
  int unsigned c_awd, c_wd, c_bd, c_ad, c_rd, c_done_poll, c_rerr_poll;
  logic [1:0]  c_bresp, c_rresp_bad;

  // Slave-side observations.
  int unsigned aw_hs, w_hs, b_hs, ar_hs, viol, ar_t1, ar_t2, scyc;

  initial begin
    int unsigned aw_c, w_c, b_c, ar_c, r_c;
    aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0; scyc = 0;
    bus.m_axi_control_awready = 1'b0;
    bus.m_axi_control_wready  = 1'b0;
    bus.m_axi_control_bvalid  = 1'b0;
    bus.m_axi_control_bresp   = 2'b00;
    bus.m_axi_control_arready = 1'b0;
    bus.m_axi_control_rvalid  = 1'b0;
    bus.m_axi_control_rresp   = 2'b00;
    bus.m_axi_control_rdata   = '0;
    forever begin
      @(negedge ap_clk);
      scyc++;
      if (!ap_rst_n) begin
        aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0;
        bus.m_axi_control_awready = 1'b0;
        bus.m_axi_control_wready  = 1'b0;
        bus.m_axi_control_bvalid  = 1'b0;
        bus.m_axi_control_arready = 1'b0;
        bus.m_axi_control_rvalid  = 1'b0;
      end else begin
        if (bus.m_axi_control_awvalid) begin
          if (bus.m_axi_control_awaddr !== CTRL_ADDR) viol++;
          if (aw_c >= c_awd) begin
            bus.m_axi_control_awready = 1'b1;
            aw_hs++;
          end else begin
            bus.m_axi_control_awready = 1'b0;
            aw_c++;
          end
        end else begin
          if (bus.m_axi_control_awaddr !== '0) viol++;
          bus.m_axi_control_awready = 1'b0;
          aw_c = 0;
        end

        if (bus.m_axi_control_wvalid) begin
          if (bus.m_axi_control_wdata !== 32'h1 || bus.m_axi_control_wstrb !== 4'hF) viol++;
          if (w_c >= c_wd) begin
            bus.m_axi_control_wready = 1'b1;
            w_hs++;
          end else begin
            bus.m_axi_control_wready = 1'b0;
            w_c++;
          end
        end else begin
          if (bus.m_axi_control_wdata !== '0 || bus.m_axi_control_wstrb !== '0) viol++;
          bus.m_axi_control_wready = 1'b0;
          w_c = 0;
        end

        if (bus.m_axi_control_bready && b_c >= c_bd) begin
          bus.m_axi_control_bvalid = 1'b1;
          bus.m_axi_control_bresp  = c_bresp;
          b_hs++;
        end else begin
          if (bus.m_axi_control_bready) b_c++;
          else b_c = 0;
          bus.m_axi_control_bvalid = 1'b0;
          bus.m_axi_control_bresp  = 2'b00;
        end

        if (bus.m_axi_control_arvalid) begin
          if (bus.m_axi_control_araddr !== CTRL_ADDR) viol++;
          if (ar_c >= c_ad) begin
            bus.m_axi_control_arready = 1'b1;
            ar_hs++;
            if (ar_hs == 1) ar_t1 = scyc;
            if (ar_hs == 2) ar_t2 = scyc;
          end else begin
            bus.m_axi_control_arready = 1'b0;
            ar_c++;
          end
        end else begin
          if (bus.m_axi_control_araddr !== '0) viol++;
          bus.m_axi_control_arready = 1'b0;
          ar_c = 0;
        end

        if (bus.m_axi_control_rready && r_c >= c_rd) begin
          bus.m_axi_control_rvalid = 1'b1;
          bus.m_axi_control_rresp  = (ar_hs == c_rerr_poll) ? c_rresp_bad : 2'b00;
          bus.m_axi_control_rdata  = ($urandom() & ~32'h2) |
                                     ((ar_hs == c_done_poll) ? 32'h2 : 32'h0);
        end else begin
          if (bus.m_axi_control_rready) r_c++;
          else r_c = 0;
          bus.m_axi_control_rvalid = 1'b0;
          bus.m_axi_control_rresp  = 2'b00;
          bus.m_axi_control_rdata  = '0;
        end
      end
    end
  end

  // Transaction-level prediction from the script: outcome, polls and cycles to done.
  task automatic predict(output logic [1:0] e, output int unsigned polls,
                         output int unsigned lat);
    int unsigned m;
    bit          stop;
    m     = (c_awd > c_wd) ? c_awd : c_wd;
    lat   = 1 + (m + 1) + (c_bd + 1);
    polls = 0;
    e     = 2'd0;
    if (c_bresp != 2'b00) begin
      e = 2'd1;
    end else begin
      stop = 1'b0;
      for (int unsigned p = 1; p <= TIMEOUT_POLLS; p++) begin
        if (!stop) begin
          polls = p;
          if (p == c_rerr_poll) begin e = 2'd2; stop = 1'b1; end
          else if (p == c_done_poll) begin e = 2'd0; stop = 1'b1; end
          else if (p == TIMEOUT_POLLS) begin e = 2'd3; stop = 1'b1; end
        end
      end
      lat = lat + polls * (c_ad + c_rd + 2) + (polls - 1) * POLL_GAP;
    end
  endtask

  task automatic set_cfg(input int unsigned awd, input int unsigned wd, input int unsigned bd,
                         input logic [1:0] bresp, input int unsigned ad, input int unsigned rd,
                         input int unsigned done_poll, input int unsigned rerr_poll,
                         input logic [1:0] rresp_bad);
    c_awd = awd; c_wd = wd; c_bd = bd; c_bresp = bresp; c_ad = ad; c_rd = rd;
    c_done_poll = done_poll; c_rerr_poll = rerr_poll; c_rresp_bad = rresp_bad;
  endtask

  task automatic run_txn(input string name, input bit hold_cmd);
    logic [1:0]  e_err;
    int unsigned e_polls, e_lat, lat;
    bit          got;
    predict(e_err, e_polls, e_lat);
    @(negedge ap_clk);
    aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; viol = 0; ar_t1 = 0; ar_t2 = 0;
    check({name, ".cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 3000) begin
      @(negedge ap_clk);
      lat++;
      if (!hold_cmd) bus.cmd_valid = 1'b0;
      if (done) got = 1'b1;
    end
    bus.cmd_valid = 1'b0;
    check({name, ".done_seen"}, 32'(got), 32'd1);
    check({name, ".latency"}, lat, e_lat);
    check({name, ".err"}, 32'(err), 32'(e_err));
    check({name, ".poll_cnt"}, 32'(poll_cnt), e_polls);
    check({name, ".ar_count"}, ar_hs, e_polls);
    check({name, ".aw_count"}, aw_hs, 32'd1);
    check({name, ".w_count"}, w_hs, 32'd1);
    check({name, ".b_count"}, b_hs, 32'd1);
    check({name, ".bus_values"}, viol, 32'd0);
    if (e_polls >= 2) check({name, ".poll_spacing"}, ar_t2 - ar_t1, c_ad + c_rd + 2 + POLL_GAP);
    @(negedge ap_clk);
    check({name, ".done_pulse"}, 32'(done), 32'd0);
    check({name, ".idle_busy"}, 32'(busy), 32'd0);
    check({name, ".err_hold"}, 32'(err), 32'(e_err));
    check({name, ".poll_hold"}, 32'(poll_cnt), e_polls);
  endtask

  initial begin
    int unsigned wait_n;
    bus.cmd_valid = 1'b0;
    set_cfg(0, 0, 0, 2'b00, 0, 0, 1, 0, 2'b00);
    ap_rst_n = 1'b0;
    repeat (3) @(negedge ap_clk);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.err", 32'(err), 32'd0);
    check("rst.poll_cnt", 32'(poll_cnt), 32'd0);
    check("rst.cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst.valids", 32'({bus.m_axi_control_awvalid, bus.m_axi_control_wvalid,
                             bus.m_axi_control_arvalid, bus.m_axi_control_bready,
                             bus.m_axi_control_rready}), 32'd0);
    ap_rst_n = 1'b1;

    set_cfg(0, 0, 0, 2'b00, 0, 0, 1, 0, 2'b00);
    run_txn("zero_wait", 1'b0);
    set_cfg(3, 0, 0, 2'b00, 0, 0, 4, 0, 2'b00);
    run_txn("w_before_aw", 1'b0);
    set_cfg(0, 0, 0, 2'b10, 0, 0, 1, 0, 2'b00);
    run_txn("bresp_err", 1'b0);
    set_cfg(0, 0, 0, 2'b00, 0, 0, 2, 2, 2'b11);
    run_txn("rresp_err", 1'b1);
    set_cfg(0, 0, 0, 2'b00, 0, 0, 99, 0, 2'b00);
    run_txn("timeout", 1'b0);

    // Reset while the read address phase is stalled.
    set_cfg(0, 0, 0, 2'b00, 20, 0, 1, 0, 2'b00);
    @(negedge ap_clk);
    bus.cmd_valid = 1'b1;
    @(negedge ap_clk);
    bus.cmd_valid = 1'b0;
    wait_n = 0;
    while (!bus.m_axi_control_arvalid && wait_n < 50) begin
      @(negedge ap_clk);
      wait_n++;
    end
    check("midrst.arvalid_seen", 32'(bus.m_axi_control_arvalid), 32'd1);
    ap_rst_n = 1'b0;
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    check("midrst.arvalid", 32'(bus.m_axi_control_arvalid), 32'd0);
    check("midrst.busy", 32'(busy), 32'd0);
    check("midrst.cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("midrst.poll_cnt", 32'(poll_cnt), 32'd0);
    set_cfg(0, 0, 0, 2'b00, 0, 0, 1, 0, 2'b00);
    run_txn("after_rst", 1'b0);

    for (int i = 0; i < 25; i++) begin
      set_cfg($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(1, 7),
              ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0,
              2'($urandom_range(1, 3)));
      run_txn($sformatf("rand%0d", i), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) @(negedge ap_clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
